// File: rtl/std_seq_div.sv
// std_seq_div: iterative unsigned restoring divider.
// Computes left / right and left % right, one quotient bit per clock,
// under a go/done handshake. One division in flight, no pipelining.
// A zero divisor takes a one-cycle short path: quotient all ones,
// remainder equal to the dividend.
module std_seq_div #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out_quotient,
    output logic [width-1:0] out_remainder,
    output logic             done
);

    localparam int CW = $clog2(width) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [width-1:0] r_dividend;
    logic [width-1:0] r_divisor;
    logic [width-1:0] r_rem;
    logic [width-1:0] r_quot;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    // The partial remainder never reaches the divisor after a restoring
    // step, so width bits suffice for storage; only the shifted trial value
    // needs the extra bit so the comparison cannot overflow.
    logic [width:0]   w_t;
    logic             w_ge;
    logic [width-1:0] w_diff;
    logic             w_last;
    logic             w_right_zero;

    assign w_t          = {r_rem, r_dividend[width-1]};
    assign w_ge         = (w_t >= {1'b0, r_divisor});
    assign w_diff       = w_t[width-1:0] - r_divisor;
    assign w_last       = (r_cnt == CW'(width - 1));
    assign w_right_zero = (right == {width{1'b0}});

    assign out_quotient  = r_quot;
    assign out_remainder = r_rem;
    assign done          = r_done;

    // Next-state decode for the IDLE/BUSY/DONE sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (go) begin
                    if (w_right_zero) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; done is registered so it is high exactly while in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Datapath: operand capture on start, one restoring step per BUSY cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dividend <= {width{1'b0}};
            r_divisor  <= {width{1'b0}};
            r_rem      <= {width{1'b0}};
            r_quot     <= {width{1'b0}};
            r_cnt      <= {CW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        if (w_right_zero) begin
                            r_quot <= {width{1'b1}};
                            r_rem  <= left;
                            r_cnt  <= {CW{1'b0}};
                        end else begin
                            r_dividend <= left;
                            r_divisor  <= right;
                            r_rem      <= {width{1'b0}};
                            r_quot     <= {width{1'b0}};
                            r_cnt      <= {CW{1'b0}};
                        end
                    end
                end
                ST_BUSY: begin
                    r_dividend <= {r_dividend[width-2:0], 1'b0};
                    r_rem      <= w_ge ? w_diff : w_t[width-1:0];
                    r_quot     <= {r_quot[width-2:0], w_ge};
                    r_cnt      <= r_cnt + CW'(1);
                end
                ST_DONE: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_std_seq_div.sv
// Self-checking bench for std_seq_div: a width-8 instance for directed
// cases and a width-16 instance for randomized operands. A timing model
// decides on each rising edge whether a request is accepted and pushes
// the expected result; a monitor on the falling edge checks every done.
module tb_std_seq_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        g8, g16;
    logic [7:0]  a8, b8, q8, r8;
    logic [15:0] a16, b16, q16, r16;
    logic        d8, d16;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int unsigned sb_q   [2][16];
    int unsigned sb_r   [2][16];
    int          sb_st  [2][16];
    int          sb_lat [2][16];
    int          wr     [2] = '{0, 0};
    int          rd     [2] = '{0, 0};
    int          free_c [2] = '{0, 0};
    logic        prev_done [2] = '{1'b0, 1'b0};
    int          last_done = -1;
    logic        held_mode = 1'b0;

    std_seq_div #(.width(8)) u_div8 (
        .clk(clk), .reset(rst_n), .go(g8), .left(a8), .right(b8),
        .out_quotient(q8), .out_remainder(r8), .done(d8)
    );

    std_seq_div #(.width(16)) u_div16 (
        .clk(clk), .reset(rst_n), .go(g16), .left(a16), .right(b16),
        .out_quotient(q16), .out_remainder(r16), .done(d16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic plus the zero-divisor rule.
    task automatic push(input int c, input int unsigned a, input int unsigned b);
        int w;
        int idx;
        w   = (c == 0) ? 8 : 16;
        idx = wr[c] % 16;
        if (b == 0) begin
            sb_q[c][idx]   = (c == 0) ? 32'hFF : 32'hFFFF;
            sb_r[c][idx]   = a;
            sb_lat[c][idx] = 1;
            free_c[c]      = cyc + 2;
        end else begin
            sb_q[c][idx]   = a / b;
            sb_r[c][idx]   = a % b;
            sb_lat[c][idx] = w + 1;
            free_c[c]      = cyc + w + 2;
        end
        sb_st[c][idx] = cyc;
        wr[c] = wr[c] + 1;
    endtask

    // Acceptance model: a request is taken when go is high and the block is free.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                rd[c]     = wr[c];
                free_c[c] = 0;
            end
        end else begin
            cyc = cyc + 1;
            if (g8 && cyc >= free_c[0])  push(0, int'(a8), int'(b8));
            if (g16 && cyc >= free_c[1]) push(1, int'(a16), int'(b16));
        end
    end

    // Monitor: compare each done against the oldest expected result.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < 2; c++) begin
                logic        dn;
                int unsigned qa, ra;
                int          idx, el;
                dn = (c == 0) ? d8 : d16;
                qa = (c == 0) ? int'(q8) : int'(q16);
                ra = (c == 0) ? int'(r8) : int'(r16);
                if (dn) chk("done_single_cycle", {31'd0, prev_done[c]}, 32'd0);
                if (rd[c] != wr[c]) begin
                    idx = rd[c] % 16;
                    el  = cyc - sb_st[c][idx] + 1;
                    if (dn) begin
                        chk("quotient", qa, sb_q[c][idx]);
                        chk("remainder", ra, sb_r[c][idx]);
                        chk("latency", el, sb_lat[c][idx]);
                        rd[c] = rd[c] + 1;
                        if (held_mode && c == 0) begin
                            if (last_done >= 0) chk("done_period", cyc - last_done, 32'd10);
                            last_done = cyc;
                        end
                    end else if (el > sb_lat[c][idx]) begin
                        chk("latency_timeout", el, sb_lat[c][idx]);
                        rd[c] = rd[c] + 1;
                    end
                end else if (dn) begin
                    chk("spurious_done", {31'd0, dn}, 32'd0);
                end
                prev_done[c] = dn;
            end
        end else begin
            prev_done[0] = 1'b0;
            prev_done[1] = 1'b0;
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        a8 = a; b8 = b; g8 = 1'b1;
        @(negedge clk);
        g8 = 1'b0;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        a16 = a; b16 = b; g16 = 1'b1;
        @(negedge clk);
        g16 = 1'b0;
    endtask

    task automatic wait_idle(input int c, input int bound);
        int k;
        k = 0;
        while (rd[c] != wr[c] && k < bound) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("wait_idle", {31'd0, rd[c] == wr[c]}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        g8 = 1'b0; g16 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; a16 = 16'd0; b16 = 16'd0;
        #3;
        chk("reset_q8", {24'd0, q8}, 32'd0);
        chk("reset_r8", {24'd0, r8}, 32'd0);
        chk("reset_done8", {31'd0, d8}, 32'd0);
        chk("reset_q16", {16'd0, q16}, 32'd0);
        chk("reset_r16", {16'd0, r16}, 32'd0);
        chk("reset_done16", {31'd0, d16}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 100/7 then five idle cycles of held results
        run8(8'd100, 8'd7);
        wait_idle(0, 20);
        repeat (5) begin
            @(negedge clk);
            chk("hold_q", {24'd0, q8}, 32'd14);
            chk("hold_r", {24'd0, r8}, 32'd2);
            chk("hold_done", {31'd0, d8}, 32'd0);
        end

        // zero divisor and boundary operands
        run8(8'd5, 8'd0);     wait_idle(0, 20);
        run8(8'd255, 8'd1);   wait_idle(0, 20);
        run8(8'd3, 8'd200);   wait_idle(0, 20);
        run8(8'd255, 8'd255); wait_idle(0, 20);
        run8(8'd200, 8'd128); wait_idle(0, 20);

        // go held high, operands changing every cycle
        held_mode = 1'b1;
        last_done = -1;
        @(negedge clk);
        g8 = 1'b1;
        repeat (60) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(1, 255));
            @(negedge clk);
        end
        g8 = 1'b0;
        wait_idle(0, 40);
        held_mode = 1'b0;

        // asynchronous reset at BUSY step 4 of 100/7
        repeat (2) @(negedge clk);
        a8 = 8'd100; b8 = 8'd7; g8 = 1'b1;
        @(negedge clk);
        g8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_q", {24'd0, q8}, 32'd0);
        chk("abort_r", {24'd0, r8}, 32'd0);
        chk("abort_done", {31'd0, d8}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("no_done_after_abort", {31'd0, d8}, 32'd0);
        end
        run8(8'd50, 8'd6);
        wait_idle(0, 20);
        chk("post_abort_q", {24'd0, q8}, 32'd8);
        chk("post_abort_r", {24'd0, r8}, 32'd2);

        // randomized width-16 operands
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb;
            int sel;
            ra  = 16'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0)      rb = 16'd0;
            else if (sel < 3)  rb = 16'($urandom_range(1, 15));
            else               rb = 16'($urandom);
            run16(ra, rb);
            wait_idle(1, 30);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        wait_idle(0, 30);
        wait_idle(1, 30);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
